// File: rtl/vectadd_trace_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vectadd_trace_mon_pkg
//  Description : Shared state encoding and width helpers for the OCI trace
//                monitor. Honours optional macro TRACE_MON_TIMESTAMP_EN.
//  Revision    : 1.0  initial release
// ============================================================================
package vectadd_trace_mon_pkg;

   typedef enum logic [1:0] {
      ST_CAPTURE   = 2'd0,
      ST_SERIALIZE = 2'd1,
      ST_DRAIN     = 2'd2,
      ST_DONE      = 2'd3
   } trace_state_e;

`ifdef TRACE_MON_TIMESTAMP_EN
   localparam bit TS_EN = 1'b1;
`else
   localparam bit TS_EN = 1'b0;
`endif

   // Width of one streamed trace word: entry alone, or {timestamp, entry}.
   function automatic int trc_width(input int entry_w, input int ts_w, input bit ts_en);
      return ts_en ? (entry_w + ts_w) : entry_w;
   endfunction

   // One extra bit so a full FIFO (DEPTH) is distinguishable from empty.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vectadd_trace_mon_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : vectadd_trace_mon_fifo
//  Description : First-word fall-through ring buffer with push/pop/flush,
//                occupancy output and a drop strobe for refused pushes.
//  Revision    : 1.0  initial release
// ============================================================================
module vectadd_trace_mon_fifo
   import vectadd_trace_mon_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = level_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic [LVL_W-1:0] o_level,
   output logic             o_drop
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic             w_full;
   logic             w_empty;
   logic             w_do_pop;
   logic             w_do_push;

   assign w_full    = (r_level == LVL_W'(DEPTH));
   assign w_empty   = (r_level == '0);
   assign w_do_pop  = i_pop && !w_empty && !i_flush;
   // A pop in the same cycle frees the slot a full-FIFO push needs.
   assign w_do_push = i_push && !i_flush && (!w_full || w_do_pop);
   assign o_drop    = i_push && !i_flush && w_full && !w_do_pop;

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
   assign o_valid = !w_empty;
   assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/vectadd_nios2_oci_trace_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : vectadd_nios2_oci_trace_monitor
//  Description : Captures packed OCI trace beats, serialises them into a ring
//                FIFO and streams them out; optional macro
//                TRACE_MON_TIMESTAMP_EN tags entries with the accept cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module vectadd_nios2_oci_trace_monitor
   import vectadd_trace_mon_pkg::*;
#(
   parameter int ENTRY_W = 10,
   parameter int LANES   = 3,
   parameter int CNT_W   = 4,
   parameter int DEPTH   = 16,
   parameter int OVF_W   = 16,
   parameter int TS_W    = 16,
   localparam int TRC_W  = trc_width(ENTRY_W, TS_W, TS_EN),
   localparam int LVL_W  = level_width(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [LANES*ENTRY_W-1:0] dct_buffer,
   input  logic [CNT_W-1:0]         dct_count,
   input  logic                     dct_valid,
   output logic                     dct_ready,
   input  logic                     test_ending,
   input  logic                     test_has_ended,
   output logic [TRC_W-1:0]         trc_data,
   output logic                     trc_valid,
   input  logic                     trc_ready,
   output logic [LVL_W-1:0]         trc_level,
   output logic [OVF_W-1:0]         ovf_count,
   output logic                     drain_done
);

   localparam int LANE_W     = idx_width(LANES);
   localparam int LANE_SLOTS = 1 << LANE_W;

   trace_state_e             r_state;
   trace_state_e             w_next;
   logic [LANES*ENTRY_W-1:0] r_buf;
   logic [LANE_W-1:0]        r_lane;
   logic [LANE_W-1:0]        r_last;
   logic                     r_end_req;
   logic [OVF_W-1:0]         r_ovf;
   logic [ENTRY_W-1:0]       w_lanes [LANE_SLOTS];
   logic [CNT_W-1:0]         w_n;
   logic                     w_accept;
   logic                     w_push;
   logic                     w_drop;
   logic                     w_last_lane;
   logic [TRC_W-1:0]         w_push_data;

   generate
      for (genvar g = 0; g < LANE_SLOTS; g++) begin : g_lane
         if (g < LANES) begin : g_real
            assign w_lanes[g] = r_buf[g*ENTRY_W +: ENTRY_W];
         end else begin : g_pad
            assign w_lanes[g] = '0;
         end
      end
   endgenerate

   assign w_n         = (dct_count > CNT_W'(LANES)) ? CNT_W'(LANES) : dct_count;
   assign w_accept    = dct_valid && dct_ready;
   assign w_last_lane = (r_lane == r_last);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_buf     <= '0;
         r_lane    <= '0;
         r_last    <= '0;
         r_end_req <= 1'b0;
      end else begin
         if (w_accept) begin
            r_buf  <= dct_buffer;
            r_lane <= '0;
            r_last <= LANE_W'(w_n - 1'b1);
         end else if (r_state == ST_SERIALIZE) begin
            r_lane <= r_lane + 1'b1;
         end
         // Remembered so a request arriving mid-beat still ends capture afterwards.
         r_end_req <= r_end_req | test_ending;
      end
   end

`ifdef TRACE_MON_TIMESTAMP_EN
   logic [TS_W-1:0] r_ts;
   logic [TS_W-1:0] r_beat_ts;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ts      <= '0;
         r_beat_ts <= '0;
      end else begin
         r_ts <= r_ts + 1'b1;
         if (w_accept) r_beat_ts <= r_ts;
      end
   end

   assign w_push_data = {r_beat_ts, w_lanes[r_lane]};
`else
   assign w_push_data = w_lanes[r_lane];
`endif

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_CAPTURE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (test_has_ended) begin
         w_next = ST_DONE;
      end else begin
         case (r_state)
            ST_CAPTURE: begin
               if (w_accept && (w_n != '0)) w_next = ST_SERIALIZE;
               else if (test_ending)        w_next = ST_DRAIN;
            end
            ST_SERIALIZE: begin
               if (w_last_lane) w_next = (r_end_req || test_ending) ? ST_DRAIN : ST_CAPTURE;
            end
            ST_DRAIN: begin
               if (trc_level == '0) w_next = ST_DONE;
            end
            default: w_next = ST_DONE;
         endcase
      end
   end

   always_comb begin
      dct_ready  = 1'b0;
      drain_done = 1'b0;
      w_push     = 1'b0;
      case (r_state)
         ST_CAPTURE:   dct_ready  = 1'b1;
         ST_SERIALIZE: w_push     = !test_has_ended;
         ST_DONE:      drain_done = 1'b1;
         default:      ;
      endcase
   end

   vectadd_trace_mon_fifo #(
      .WIDTH (TRC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (reset),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .i_pop       (trc_ready),
      .i_flush     (test_has_ended),
      .o_data      (trc_data),
      .o_valid     (trc_valid),
      .o_level     (trc_level),
      .o_drop      (w_drop)
   );

   always_ff @(posedge clk) begin
      if (reset)                         r_ovf <= '0;
      else if (w_drop && (r_ovf != '1))  r_ovf <= r_ovf + 1'b1;
   end

   assign ovf_count = r_ovf;

endmodule
`default_nettype wire
